// File: rtl/multiplexor_afisaj.sv
// Time-multiplexed scanner for a common-anode 7-segment display with
// frame-synchronous double buffering and optional leading-zero blanking.
module multiplexor_afisaj #(
    parameter int NR_CIFRE = 4,
    parameter int DIV      = 50000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4*NR_CIFRE-1:0] valoare_i,
    input  logic                  valid_i,
    input  logic                  blank_zero_i,
    output logic [3:0]            cifra_o,
    output logic [NR_CIFRE-1:0]   anod_o,
    output logic                  frame_o
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NR_CIFRE > 1) ? $clog2(NR_CIFRE) : 1;

    logic [PW-1:0]           presc_r;
    logic [IW-1:0]           idx_r;
    logic [4*NR_CIFRE-1:0]   pending_r;
    logic [4*NR_CIFRE-1:0]   afisat_r;
    logic                    pend_v_r;
    logic                    bnd_d_r;
    logic                    tick_s;
    logic                    boundary_s;
    logic [NR_CIFRE-1:0]     blank_s;
    logic [3:0]              nib_s;
    logic                    cur_blank_s;
    logic [NR_CIFRE-1:0]     one_hot_s;

    // Prescaler tick and frame boundary detection
    always_comb begin
        tick_s     = (presc_r == PW'(DIV - 1));
        boundary_s = tick_s && (idx_r == IW'(NR_CIFRE - 1));
    end

    // Per-digit blanking: digit k is blank when it and every higher nibble are zero
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_s    = '0;
        for (int k = NR_CIFRE - 1; k >= 1; k--) begin
            zero_above = zero_above && (afisat_r[4*k +: 4] == 4'h0);
            blank_s[k] = blank_zero_i && zero_above;
        end
    end

    // Select the nibble, blank flag and anode for the current digit index
    always_comb begin
        nib_s       = 4'h0;
        cur_blank_s = 1'b0;
        for (int k = 0; k < NR_CIFRE; k++) begin
            nib_s       = (idx_r == IW'(k)) ? afisat_r[4*k +: 4] : nib_s;
            cur_blank_s = (idx_r == IW'(k)) ? blank_s[k] : cur_blank_s;
        end
        one_hot_s = {{(NR_CIFRE-1){1'b0}}, 1'b1} << idx_r;
    end

    // Scan counters, double buffer and registered display outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_r   <= '0;
            idx_r     <= '0;
            pending_r <= '0;
            afisat_r  <= '0;
            pend_v_r  <= 1'b0;
            bnd_d_r   <= 1'b0;
            cifra_o   <= 4'h0;
            anod_o    <= '1;
            frame_o   <= 1'b0;
        end else begin
            presc_r <= tick_s ? '0 : presc_r + PW'(1);
            if (boundary_s) begin
                idx_r <= '0;
            end else if (tick_s) begin
                idx_r <= idx_r + IW'(1);
            end else begin
                idx_r <= idx_r;
            end

            // A strobe landing on the boundary bypasses the pending buffer
            if (valid_i) begin
                pending_r <= valoare_i;
            end else begin
                pending_r <= pending_r;
            end
            if (boundary_s && valid_i) begin
                afisat_r <= valoare_i;
                pend_v_r <= 1'b0;
            end else if (boundary_s && pend_v_r) begin
                afisat_r <= pending_r;
                pend_v_r <= 1'b0;
            end else if (valid_i) begin
                afisat_r <= afisat_r;
                pend_v_r <= 1'b1;
            end else begin
                afisat_r <= afisat_r;
                pend_v_r <= pend_v_r;
            end

            // Outputs lag idx/afisat by one cycle, so the frame pulse lags the boundary too
            bnd_d_r <= boundary_s;
            frame_o <= bnd_d_r;
            cifra_o <= cur_blank_s ? 4'h0 : nib_s;
            anod_o  <= cur_blank_s ? {NR_CIFRE{1'b1}} : ~one_hot_s;
        end
    end

endmodule

// File: tb/tb_multiplexor_afisaj.sv
// Randomized and directed bench for multiplexor_afisaj against a
// frame-level behavioural model (DIV=4, NR_CIFRE=4).
module tb_multiplexor_afisaj;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] valoare_i = 16'h0;
    logic        valid_i = 1'b0;
    logic        blank_zero_i = 1'b0;
    logic [3:0]  cifra_o;
    logic [3:0]  anod_o;
    logic        frame_o;

    multiplexor_afisaj #(.NR_CIFRE(4), .DIV(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valoare_i    (valoare_i),
        .valid_i      (valid_i),
        .blank_zero_i (blank_zero_i),
        .cifra_o      (cifra_o),
        .anod_o       (anod_o),
        .frame_o      (frame_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: a frame is 16 cycles; the value shown in a frame is the last
    // strobe taken during the previous frame (or unchanged if none).
    int          t = 0;
    logic [15:0] disp = 16'h0;
    logic [15:0] cand = 16'h0;
    logic        cand_v = 1'b0;
    logic        bz = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic cyc(input logic r, input logic v, input logic [15:0] val);
        logic [3:0] ec;
        logic [3:0] ea;
        logic       ef;
        logic       bl;
        logic [3:0] one;
        int         d;
        rst_i        = r;
        valid_i      = v;
        valoare_i    = val;
        blank_zero_i = bz;
        one          = 4'b0001;
        if (r) begin
            ec = 4'h0;
            ea = 4'hF;
            ef = 1'b0;
        end else begin
            d  = (t % 16) / 4;
            bl = bz && (d >= 1) && ((disp >> (4 * d)) == 16'h0);
            ec = bl ? 4'h0 : 4'((disp >> (4 * d)) & 16'hF);
            ea = bl ? 4'hF : ~(one << d);
            ef = ((t % 16) == 0) && (t >= 16);
        end
        @(posedge clk_i);
        #1;
        n_vec++;
        assert (cifra_o === ec) else begin
            n_err++;
            $error("FAIL cifra t=%0d rst=%0b observed=%h expected=%h", t, r, cifra_o, ec);
        end
        n_vec++;
        assert (anod_o === ea) else begin
            n_err++;
            $error("FAIL anod t=%0d rst=%0b observed=%b expected=%b", t, r, anod_o, ea);
        end
        n_vec++;
        assert (frame_o === ef) else begin
            n_err++;
            $error("FAIL frame t=%0d rst=%0b observed=%b expected=%b", t, r, frame_o, ef);
        end
        if (r) begin
            disp   = 16'h0;
            cand_v = 1'b0;
            t      = 0;
        end else begin
            if (v) begin
                cand   = val;
                cand_v = 1'b1;
            end
            if ((t % 16) == 15 && cand_v) begin
                disp   = cand;
                cand_v = 1'b0;
            end
            t++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0);
    endtask

    task automatic go_phase(input int p);
        for (int i = 0; i < 16 && (t % 16) != p; i++) cyc(1'b0, 1'b0, 16'h0);
    endtask

    task automatic strobe(input logic [15:0] val);
        cyc(1'b0, 1'b1, val);
    endtask

    initial begin
        logic [15:0] rv;
        logic        rvld;
        logic        rrst;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0);
        idle(5);
        strobe(16'h1234);
        idle(30);
        go_phase(4);
        strobe(16'h5678);
        idle(30);
        strobe(16'h1111);
        idle(2);
        strobe(16'h2222);
        idle(30);
        go_phase(15);
        strobe(16'h9999);
        idle(20);
        bz = 1'b1;
        strobe(16'h0045);
        idle(36);
        strobe(16'h0000);
        idle(36);
        strobe(16'h1005);
        idle(36);
        strobe(16'h00A0);
        idle(36);
        // Reset mid-scan with a value pending; it must never appear
        go_phase(6);
        strobe(16'h4321);
        idle(2);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0);
        idle(36);
        for (int i = 0; i < 900; i++) begin
            if ((i % 64) == 0) bz = 1'($urandom_range(0, 1));
            rv   = 16'($urandom) >> (4 * $urandom_range(0, 3));
            rvld = ($urandom_range(0, 7) == 0);
            rrst = ($urandom_range(0, 299) == 0);
            cyc(rrst, rvld, rv);
        end
        idle(40);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multiplexor_afisaj.md
# multiplexor_afisaj

Time-multiplexed scanner for an NR_CIFRE-digit common-anode 7-segment display. It sits directly upstream of the BCD-to-7-segment decoder. Each cycle it presents one BCD digit on `cifra_o` to the decoder and drives the matching active-low anode. New values are double-buffered so the display only changes at frame boundaries, which prevents tearing. Optional leading-zero blanking is included.

## Interface
Parameters:
- `NR_CIFRE`, 4: number of digits scanned; supported range 2..8.
- `DIV`, 50000: clock cycles each digit stays lit; minimum 2.

Ports (clock and reset first):
- `clk_i` input 1: single clock; all state changes on its rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `valoare_i` input 4*NR_CIFRE: BCD value; nibble k is digit k, digit 0 is rightmost/least significant.
- `valid_i` input 1: single-cycle strobe that captures `valoare_i` into the pending buffer.
- `blank_zero_i` input 1: 1 = blank leading zeros.
- `cifra_o` output 4: current digit value, wired to the decoder input.
- `anod_o` output NR_CIFRE: active-low anode selects; at most one bit is low.
- `frame_o` output 1: one-cycle pulse at each frame boundary.

## Operation
- **Prescaler**
  - `presc` counts 0..DIV-1 and wraps to 0.
  - `tick` = (`presc` == DIV-1).
- **Digit index**
  - `idx` counts 0..NR_CIFRE-1 and advances on `tick`.
  - It wraps from NR_CIFRE-1 to 0. This wrap is the frame boundary.
- **Buffers**
  - `pending` register, `afisat` (displayed) register, and `pend_v` flag.
  - `valid_i`=1: `pending` <= `valoare_i` and `pend_v` <= 1. The last strobe before a boundary wins.
  - Frame boundary with `pend_v`=1: `afisat` <= `pending` and `pend_v` <= 0.
  - `valid_i` in the same cycle as a boundary: the new value loads `afisat` directly and `pend_v` <= 0.
  - `afisat` never changes except at a frame boundary.
- **Blanking**
  - Digit k (k≥1) is blank when `blank_zero_i`=1 and nibbles k..NR_CIFRE-1 of `afisat` are all zero.
  - Digit 0 is never blanked.
  - A nibble counts as nonzero whenever it is not 4'h0, including illegal codes.
- **Outputs** (registered, updated every cycle from the current `idx`/`afisat`):
  - `cifra_o` <= nibble `idx` of `afisat`, or 4'h0 if the digit is blank.
  - `anod_o` <= all ones with bit `idx` cleared, or all ones if the digit is blank.
  - `frame_o` <= 1 in the cycle the boundary takes effect, else 0.
- Nibbles >9 pass through unchanged; the decoder then displays its error pattern.
- `blank_zero_i` is sampled live and affects the next output update.

## Timing
- **Reset** (`rst_i`=1 at an edge):
  - `presc`=0, `idx`=0, `afisat`=0, `pending`=0, `pend_v`=0.
  - `anod_o`=all ones, `cifra_o`=4'h0, `frame_o`=0.
- **First cycle after reset release:** `anod_o`=~1 (digit 0 lit), `cifra_o`=0.
- **Output latency:** outputs lag `idx`/`afisat` by one cycle.
  - Digit k is lit for exactly DIV cycles.
  - A frame lasts NR_CIFRE*DIV cycles.
- **`frame_o`:** asserted in the same cycle `anod_o` first shows digit 0 of the new frame and `cifra_o` shows the new `afisat`.
- **Update latency:** `valid_i` to the value being visible is at most NR_CIFRE*DIV+1 cycles.
- **Reset mid-frame:** takes effect at the next edge regardless of `presc`/`idx`/`pend_v`. Any pending value is discarded.

## Test plan
Use DIV=4, NR_CIFRE=4.
1. **Reset:** hold `rst_i` 3 cycles mid-scan with `pend_v`=1 -> during reset `anod_o`=1111, `cifra_o`=0, `frame_o`=0. One cycle after release `anod_o`=1110, `cifra_o`=0. The pending value is never shown.
2. **Scan order:** `valid_i` with 16'h1234, `blank_zero_i`=0 -> after the first boundary, `cifra_o`/`anod_o` cycle 4/1110, 3/1101, 2/1011, 1/0111, each for 4 cycles. `frame_o` pulses every 16 cycles, aligned with 1110.
3. **No tearing:** while showing 16'h1234, strobe 16'h5678 when `idx`=1 -> digits 2 and 3 still show 2 and 1. The next frame shows 8, 7, 6, 5.
4. **Last wins / boundary collision:**
   - Strobes 16'h1111 and 16'h2222 in one frame -> the next frame shows 2222 only.
   - Strobe 16'h9999 exactly on the boundary cycle -> the following frame shows 9999.
5. **Blanking:** `blank_zero_i`=1.
   - 16'h0045 -> digits 3 and 2 give `anod_o`=1111; digit 1 = 4/1101; digit 0 = 5/1110.
   - 16'h0000 -> only digit 0 is lit, showing 0.
   - 16'h1005 -> all four digits are lit.
6. **Illegal code:** 16'h00A0, `blank_zero_i`=1 -> digit 1 shows `cifra_o`=4'hA with `anod_o`=1101, digit 0 shows 0, and digits 3 and 2 are blank.
